// File: rtl/iq_fifo_pkg.sv
// Shared widths and entry-packing helper for the IF->ID instruction queue.
// Optional feature macro: IQ_PRED_EN (adds a predicted-taken column).
package iq_fifo_pkg;

   localparam int INST_W_DEF = 32;
   localparam int PC_W_DEF   = 32;

`ifdef IQ_PRED_EN
   localparam int PRED_W = 1;
`else
   localparam int PRED_W = 0;
`endif

   // Stored entry layout, LSB first: inst, pc, [pred].
   function automatic int entry_w(input int inst_w, input int pc_w);
      return inst_w + pc_w + PRED_W;
   endfunction

endpackage

// File: rtl/iq_fifo_if.sv
// Fetch-side and decode-side handshake bundle for iq_fifo.
// Optional feature macro: IQ_PRED_EN (pred_in/pred_out).
interface iq_fifo_if import iq_fifo_pkg::*; #(
   parameter int DEPTH  = 16,
   parameter int INST_W = INST_W_DEF,
   parameter int PC_W   = PC_W_DEF
) ();

   logic                     push;
   logic [INST_W-1:0]        inst_in;
   logic [PC_W-1:0]          pc_in;
   logic                     wr_en;
   logic                     pop;
   logic                     valid;
   logic [INST_W-1:0]        inst_out;
   logic [PC_W-1:0]          pc_out;
   logic [$clog2(DEPTH):0]   count;
`ifdef IQ_PRED_EN
   logic                     pred_in;
   logic                     pred_out;
`endif

   modport master (
`ifdef IQ_PRED_EN
      output pred_in,
      input  pred_out,
`endif
      output push, inst_in, pc_in, pop,
      input  wr_en, valid, inst_out, pc_out, count
   );

   modport slave (
`ifdef IQ_PRED_EN
      input  pred_in,
      output pred_out,
`endif
      input  push, inst_in, pc_in, pop,
      output wr_en, valid, inst_out, pc_out, count
   );

endinterface

// File: rtl/iq_ram.sv
// Entry storage for iq_fifo: one synchronous write port, one asynchronous read port.
// Optional feature macro: IQ_PRED_EN (only widens DATA_W via the caller).
module iq_ram #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int DATA_W = 64
) (
   input  logic              clk_in,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: the array has no reset; count/valid decide whether a slot is meaningful,
   // and leaving it unreset lets it map onto plain RAM.
   always_ff @(posedge clk_in) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/iq_fifo.sv
// Instruction queue between IF and ID with registered show-ahead outputs and early wr_en stall.
// Optional feature macro: IQ_PRED_EN (stores and presents a predicted-taken bit).
module iq_fifo import iq_fifo_pkg::*; #(
   parameter int DEPTH       = 16,
   parameter int ADDR_W      = $clog2(DEPTH),
   parameter int INST_W      = INST_W_DEF,
   parameter int PC_W        = PC_W_DEF,
   parameter int AFULL_SLACK = 2
) (
   input  logic      clk_in,
   input  logic      rst_in,
   input  logic      rdy_in,
   input  logic      clear,
   iq_fifo_if.slave  q
);

   localparam int CNT_W   = ADDR_W + 1;
   localparam int ENTRY_W = entry_w(INST_W, PC_W);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] SLACK_C = CNT_W'(AFULL_SLACK);

   logic [ADDR_W-1:0]  head_q, tail_q, head_next, tail_next;
   logic [CNT_W-1:0]   count_q, count_next;
   logic               valid_q, wr_en_q;
   logic [ENTRY_W-1:0] out_q, out_next, wr_entry, rd_entry;
   logic               push_acc, pop_acc, bypass, ram_we;

`ifdef IQ_PRED_EN
   assign wr_entry = {q.pred_in, q.pc_in, q.inst_in};
`else
   assign wr_entry = {q.pc_in, q.inst_in};
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      push_acc   = q.push && (count_q != DEPTH_C);
      pop_acc    = q.pop && valid_q;
      head_next  = head_q;
      tail_next  = tail_q;
      if (pop_acc)  head_next = head_q + ADDR_W'(1);
      if (push_acc) tail_next = tail_q + ADDR_W'(1);
      count_next = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
      // The new entry is the oldest survivor whenever the queue would otherwise be empty.
      bypass     = push_acc && ((count_q == '0) || ((count_q == CNT_W'(1)) && pop_acc));
      out_next   = out_q;
      if (bypass)       out_next = wr_entry;
      else if (pop_acc) out_next = rd_entry;
   end

   assign ram_we = push_acc && rdy_in && !rst_in && !clear;

   iq_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (ENTRY_W)
   ) u_ram (
      .clk_in (clk_in),
      .we     (ram_we),
      .waddr  (tail_q),
      .wdata  (wr_entry),
      .raddr  (head_next),
      .rdata  (rd_entry)
   );

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_in) begin
      if (rst_in || clear) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         wr_en_q <= 1'b1;
         out_q   <= '0;
      end else if (rdy_in) begin
         head_q  <= head_next;
         tail_q  <= tail_next;
         count_q <= count_next;
         valid_q <= (count_next != '0);
         wr_en_q <= (DEPTH_C - count_next) > SLACK_C;
         out_q   <= out_next;
      end
   end

   assign q.wr_en    = wr_en_q;
   assign q.valid    = valid_q;
   assign q.count    = count_q;
   assign q.inst_out = out_q[INST_W-1:0];
   assign q.pc_out   = out_q[INST_W +: PC_W];
`ifdef IQ_PRED_EN
   assign q.pred_out = out_q[ENTRY_W-1];
`endif

endmodule

// File: tb/tb_iq_fifo.sv
// Directed self-checking bench for iq_fifo (DEPTH=16, AFULL_SLACK=2).
// Exercises pred_in/pred_out only when IQ_PRED_EN is defined.
module tb_iq_fifo;

   logic clk_in = 1'b0;
   logic rst_in;
   logic rdy_in;
   logic clear;
   int   checks = 0;
   int   errors = 0;

   iq_fifo_if #(.DEPTH(16), .INST_W(32), .PC_W(32)) bus ();

   iq_fifo #(
      .DEPTH       (16),
      .AFULL_SLACK (2)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .clear  (clear),
      .q      (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic p, input logic [31:0] inst, input logic [31:0] pc,
                        input logic pr, input logic o);
      bus.push    = p;
      bus.inst_in = inst;
      bus.pc_in   = pc;
      bus.pop     = o;
`ifdef IQ_PRED_EN
      bus.pred_in = pr;
`else
      if (pr) begin end
`endif
   endtask

   task automatic do_reset();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      rst_in = 1'b1;
      tick();
      tick();
      rst_in = 1'b0;
   endtask

   initial begin
      rdy_in = 1'b1;
      clear  = 1'b0;
      do_reset();

      // Reset state
      check("rst_count", bus.count, 0);
      check("rst_valid", bus.valid, 0);
      check("rst_wr_en", bus.wr_en, 1);
      check("rst_inst",  bus.inst_out, 0);
      check("rst_pc",    bus.pc_out, 0);
`ifdef IQ_PRED_EN
      check("rst_pred",  bus.pred_out, 0);
`endif

      // Single push, 1-cycle latency
      drive(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("one_valid", bus.valid, 1);
      check("one_inst",  bus.inst_out, 32'h0000_0013);
      check("one_pc",    bus.pc_out, 0);
      check("one_count", bus.count, 1);

      // Fill with no pops: 18 pushes, last two dropped, wr_en drops after the 14th
      do_reset();
      for (int i = 0; i < 18; i++) begin
         drive(1'b1, 32'h1000 + 32'(i), 32'(i * 4), 1'b0, 1'b0);
         tick();
         check($sformatf("fill_count_%0d", i), bus.count, (i < 16) ? i + 1 : 16);
         check($sformatf("fill_wr_en_%0d", i), bus.wr_en, (i < 13) ? 1 : 0);
         check($sformatf("fill_head_%0d", i), bus.pc_out, 0);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Drain 16 in order; wr_en returns once free space exceeds 2
      for (int i = 0; i < 16; i++) begin
         check($sformatf("drain_pc_%0d", i),   bus.pc_out, i * 4);
         check($sformatf("drain_inst_%0d", i), bus.inst_out, 32'h1000 + i);
         drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
         tick();
         check($sformatf("drain_count_%0d", i), bus.count, 15 - i);
         check($sformatf("drain_wr_en_%0d", i), bus.wr_en, (i >= 2) ? 1 : 0);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("drain_valid", bus.valid, 0);

      // Continuous push+pop for 40 cycles from count=1 (pointers wrap twice)
      do_reset();
      drive(1'b1, 32'h2000, 32'h100, 1'b0, 1'b0);
      tick();
      for (int i = 1; i <= 40; i++) begin
         drive(1'b1, 32'h2000 + 32'(i), 32'h100 + 32'(i * 4), 1'b0, 1'b1);
         tick();
         check($sformatf("stream_count_%0d", i), bus.count, 1);
         check($sformatf("stream_pc_%0d", i),    bus.pc_out, 32'h100 + i * 4);
         check($sformatf("stream_inst_%0d", i),  bus.inst_out, 32'h2000 + i);
      end

      // From the wrapped pointers, queue 10 more and drain 11 through the array
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 32'h3000 + 32'(k), 32'h200 + 32'(k * 4), 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("wrap_count", bus.count, 11);
      check("wrap_head", bus.pc_out, 32'h1A0);
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
         tick();
         check($sformatf("wrap_pc_%0d", k),   bus.pc_out, 32'h200 + k * 4);
         check($sformatf("wrap_inst_%0d", k), bus.inst_out, 32'h3000 + k);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("wrap_empty", bus.valid, 0);

      // Clear with a simultaneous push: clear wins and the entry is discarded
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 32'h4000 + 32'(k), 32'h400 + 32'(k * 4), 1'b0, 1'b0);
         tick();
      end
      check("pre_clear_count", bus.count, 5);
      clear = 1'b1;
      drive(1'b1, 32'h4FFF, 32'h4FF, 1'b1, 1'b1);
      tick();
      clear = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("clear_count", bus.count, 0);
      check("clear_valid", bus.valid, 0);
      check("clear_wr_en", bus.wr_en, 1);
      check("clear_pc",    bus.pc_out, 0);
      check("clear_inst",  bus.inst_out, 0);
      drive(1'b1, 32'h5000, 32'h500, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h5004, 32'h504, 1'b0, 1'b0);
      tick();
      check("post_clear_pc",    bus.pc_out, 32'h500);
      check("post_clear_count", bus.count, 2);

      // rdy_in low for 3 cycles with push and pop held: everything frozen
      rdy_in = 1'b0;
      drive(1'b1, 32'h5008, 32'h508, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("hold_count_%0d", k), bus.count, 2);
         check($sformatf("hold_valid_%0d", k), bus.valid, 1);
         check($sformatf("hold_pc_%0d", k),    bus.pc_out, 32'h500);
         check($sformatf("hold_inst_%0d", k),  bus.inst_out, 32'h5000);
      end
      rdy_in = 1'b1;
      tick();
      check("resume_pc",    bus.pc_out, 32'h504);
      check("resume_count", bus.count, 2);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      check("resume_pc2",    bus.pc_out, 32'h508);
      check("resume_inst2",  bus.inst_out, 32'h5008);
      check("resume_count2", bus.count, 1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("resume_empty", bus.valid, 0);

      // Steady push+pop at count=2 through wrap: reads come from the array, pred alternates
      do_reset();
      drive(1'b1, 32'h6000, 32'h700, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'h6001, 32'h704, 1'b0, 1'b0);
      tick();
      for (int j = 2; j < 24; j++) begin
         drive(1'b1, 32'h6000 + 32'(j), 32'h700 + 32'(j * 4), (j % 2) == 0, 1'b1);
         tick();
         check($sformatf("pred_count_%0d", j), bus.count, 2);
         check($sformatf("pred_pc_%0d", j),    bus.pc_out, 32'h700 + (j - 1) * 4);
`ifdef IQ_PRED_EN
         check($sformatf("pred_bit_%0d", j),   bus.pred_out, ((j - 1) % 2) == 0);
`endif
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
